// File: rtl/mac8_pkg.sv
// Shared constants and state encoding for the MAC8 operand sequencer.
package mac8_pkg;

    localparam int OP_W   = 6;
    localparam int RES_W  = 2 * OP_W;
    localparam int NUM_PP = OP_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        DONE = 3'd4
    } mac8_state_e;

endpackage

// File: rtl/mac8_pp_gen.sv
// Combinational partial-product generator: pp[i] = y[i] ? (x << i) : 0.
module mac8_pp_gen
    import mac8_pkg::*;
(
    input  logic [OP_W-1:0]              x,
    input  logic [OP_W-1:0]              y,
    output logic [NUM_PP-1:0][RES_W-1:0] pp
);

    generate
        for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_pp
            assign pp[gi] = y[gi] ? (RES_W'(x) << gi) : '0;
        end
    endgenerate

endmodule

// File: rtl/mac8_operand_sequencer.sv
// Sequences a 6x6 multiply(-accumulate) through an external three-operand
// adder over three passes and returns the result over a valid/ready handshake.
module mac8_operand_sequencer
    import mac8_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_x,
    input  logic [OP_W-1:0]  in_y,
    input  logic             in_acc_en,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_result,
    output logic             out_ovf,
    output logic [RES_W-1:0] add_a,
    output logic [RES_W-1:0] add_b,
    output logic [RES_W-1:0] add_c,
    input  logic [RES_W-1:0] add_sum,
    input  logic             add_carry
);

    mac8_state_e state_q, state_d;

    logic [OP_W-1:0]  x_q, x_d;
    logic [OP_W-1:0]  y_q, y_d;
    logic             acc_en_q, acc_en_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [RES_W-1:0] partial_q, partial_d;
    logic [RES_W-1:0] add_b_q, add_b_d;
    logic [RES_W-1:0] add_c_q, add_c_d;
    logic [RES_W-1:0] out_result_q, out_result_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [OP_W-1:0]              pp_x;
    logic [OP_W-1:0]              pp_y;
    logic [NUM_PP-1:0][RES_W-1:0] pp;
    logic                         hs;

    // Operands are registered one cycle ahead of the pass that uses them, so
    // in IDLE the generator must see the incoming request, not the latches.
    assign pp_x = (state_q == IDLE) ? in_x : x_q;
    assign pp_y = (state_q == IDLE) ? in_y : y_q;

    mac8_pp_gen u_pp_gen (
        .x  (pp_x),
        .y  (pp_y),
        .pp (pp)
    );

    assign in_ready   = (state_q == IDLE);
    assign hs         = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_ovf    = out_ovf_q;
    // Operand A doubles as the running partial sum, so it is that flop itself.
    assign add_a      = partial_q;
    assign add_b      = add_b_q;
    assign add_c      = add_c_q;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        acc_en_d     = acc_en_q;
        acc_d        = acc_q;
        partial_d    = '0;
        add_b_d      = '0;
        add_c_d      = '0;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        out_valid_d  = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (acc_clear) begin
                    acc_d = '0;
                end
                if (hs) begin
                    x_d       = in_x;
                    y_d       = in_y;
                    acc_en_d  = in_acc_en;
                    partial_d = pp[0];
                    add_b_d   = pp[1];
                    add_c_d   = pp[2];
                    state_d   = P1;
                end
            end
            P1: begin
                partial_d = add_sum;
                add_b_d   = pp[3];
                add_c_d   = pp[4];
                state_d   = P2;
            end
            P2: begin
                partial_d = add_sum;
                add_b_d   = pp[5];
                add_c_d   = acc_en_q ? acc_q : '0;
                state_d   = P3;
            end
            P3: begin
                out_result_d = add_sum;
                out_ovf_d    = add_carry;
                acc_d        = add_sum;
                out_valid_d  = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            acc_en_q     <= 1'b0;
            acc_q        <= '0;
            partial_q    <= '0;
            add_b_q      <= '0;
            add_c_q      <= '0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            acc_en_q     <= acc_en_d;
            acc_q        <= acc_d;
            partial_q    <= partial_d;
            add_b_q      <= add_b_d;
            add_c_q      <= add_c_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
            out_valid_q  <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mac8_operand_sequencer.sv
// Self-checking bench: external adder model plus an arithmetic MAC reference.
module tb_mac8_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_x;
    logic [5:0]  in_y;
    logic        in_acc_en;
    logic        acc_clear;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_result;
    logic        out_ovf;
    logic [11:0] add_a;
    logic [11:0] add_b;
    logic [11:0] add_c;
    logic [11:0] add_sum;
    logic        add_carry;
    logic [13:0] add_full;

    int checks   = 0;
    int failures = 0;
    int model_acc = 0;

    always #5 clk = ~clk;

    // Three-operand adder: 12-bit sum, carry when anything spills past bit 11.
    always_comb begin
        add_full  = 14'(add_a) + 14'(add_b) + 14'(add_c);
        add_sum   = add_full[11:0];
        add_carry = |add_full[13:12];
    end

    mac8_operand_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_acc_en  (in_acc_en),
        .acc_clear  (acc_clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_c      (add_c),
        .add_sum    (add_sum),
        .add_carry  (add_carry)
    );

    // Reference: result = x*y (+ acc) mod 4096, ovf when the true sum >= 4096.
    task automatic model_op(input int x, input int y, input bit ae, input bit clr,
                            output int res, output bit ovf);
        int total;
        total = x * y + ((ae && !clr) ? model_acc : 0);
        res = total % 4096;
        ovf = (total >= 4096);
        model_acc = res;
    endtask

    // Issues one request from IDLE with out_ready high; returns what came back.
    task automatic do_op(input logic [5:0] x, input logic [5:0] y, input bit ae, input bit clr,
                         output int res, output bit ovf, output int lat, output bit to);
        in_x = x; in_y = y; in_acc_en = ae; acc_clear = clr; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clear = 1'b0; in_acc_en = 1'b0;
        lat = 0; to = 1'b0;
        while (!out_valid) begin
            @(posedge clk); #1;
            lat++;
            if (lat > 20) begin to = 1'b1; break; end
        end
        res = int'(out_result);
        ovf = out_ovf;
        @(posedge clk); #1;
        $display("op x=%0d y=%0d acc_en=%0d clr=%0d -> result=%0d ovf=%0d lat=%0d", x, y, ae, clr, res, ovf, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_x = 0; in_y = 0; in_acc_en = 0; acc_clear = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_result !== 12'd0 || out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out got=%0d/%0b exp=0/0", out_result, out_ovf); end
        checks++; if ({add_a, add_b, add_c} !== 36'd0) begin failures++; $display("FAIL reset_add got=%0d,%0d,%0d exp=0,0,0", add_a, add_b, add_c); end
        rst = 1'b0;
        model_acc = 0;
        $display("reset done");
    endtask

    task automatic test_basic();
        int r, l; bit o, t;
        do_op(6'd5, 6'd7, 1'b0, 1'b0, r, o, l, t);
        checks++; if (t) begin failures++; $display("FAIL basic_timeout got=timeout exp=out_valid"); end
        checks++; if (l !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", l); end
        checks++; if (r !== 35 || o !== 1'b0) begin failures++; $display("FAIL basic_result got=%0d/%0b exp=35/0", r, o); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_return_idle got=in_ready %0b out_valid %0b exp=1/0", in_ready, out_valid); end
        model_acc = 35;
    endtask

    task automatic test_wrap();
        int r, l; bit o, t;
        do_op(6'd63, 6'd63, 1'b0, 1'b0, r, o, l, t);
        checks++; if (t || r !== 3969 || o !== 1'b0) begin failures++; $display("FAIL max_product got=%0d/%0b exp=3969/0", r, o); end
        do_op(6'd63, 6'd63, 1'b1, 1'b0, r, o, l, t);
        checks++; if (t || r !== 3842 || o !== 1'b1) begin failures++; $display("FAIL wrap_acc got=%0d/%0b exp=3842/1", r, o); end
        // y=0 with accumulate exposes the held accumulator
        do_op(6'd17, 6'd0, 1'b1, 1'b0, r, o, l, t);
        checks++; if (t || r !== 3842 || o !== 1'b0) begin failures++; $display("FAIL wrap_acc_held got=%0d/%0b exp=3842/0", r, o); end
        model_acc = 3842;
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        in_x = 6'd3; in_y = 6'd4; in_acc_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (!out_valid) begin failures++; $display("FAIL bp_timeout got=no out_valid exp=out_valid"); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_x = 6'($urandom_range(0, 63)); in_y = 6'($urandom_range(0, 63));
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_result !== 12'd12 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=valid %0b result %0d in_ready %0b exp=1/12/0", i, out_valid, out_result, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=valid %0b in_ready %0b exp=0/1", out_valid, in_ready); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_single_transfer got=%0b exp=0", out_valid); end
        $display("backpressure hold x=3 y=4 result=12");
        model_acc = 12;
    endtask

    task automatic test_acc_clear();
        int r, l; bit o, t;
        do_op(6'd10, 6'd10, 1'b0, 1'b0, r, o, l, t);
        checks++; if (t || r !== 100) begin failures++; $display("FAIL clr_setup got=%0d exp=100", r); end
        do_op(6'd2, 6'd3, 1'b1, 1'b1, r, o, l, t);
        checks++; if (t || r !== 6 || o !== 1'b0) begin failures++; $display("FAIL clr_wins got=%0d/%0b exp=6/0", r, o); end
        model_acc = 6;
    endtask

    task automatic test_mid_reset();
        int r, l; bit o, t;
        in_x = 6'd9; in_y = 6'd9; in_acc_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (add_a !== 12'd9 || add_b !== 12'd0 || add_c !== 12'd0) begin failures++; $display("FAIL p1_operands got=%0d,%0d,%0d exp=9,0,0", add_a, add_b, add_c); end
        @(posedge clk); #1;
        checks++; if (add_a !== 12'd9 || add_b !== 12'd72 || add_c !== 12'd0) begin failures++; $display("FAIL p2_operands got=%0d,%0d,%0d exp=9,72,0", add_a, add_b, add_c); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || {add_a, add_b, add_c} !== 36'd0) begin
            failures++; $display("FAIL mid_reset got=valid %0b in_ready %0b add %0d,%0d,%0d exp=0/1/0", out_valid, in_ready, add_a, add_b, add_c);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_no_output got=%0b exp=0", out_valid); end
        model_acc = 0;
        do_op(6'd1, 6'd1, 1'b1, 1'b0, r, o, l, t);
        checks++; if (t || r !== 1 || o !== 1'b0) begin failures++; $display("FAIL after_reset got=%0d/%0b exp=1/0", r, o); end
        model_acc = 1;
    endtask

    task automatic test_zero();
        int r, l; bit o, t;
        do_op(6'd20, 6'd25, 1'b0, 1'b0, r, o, l, t);
        checks++; if (t || r !== 500) begin failures++; $display("FAIL zero_setup got=%0d exp=500", r); end
        do_op(6'($urandom_range(0, 63)), 6'd0, 1'b1, 1'b0, r, o, l, t);
        checks++; if (t || r !== 500 || o !== 1'b0) begin failures++; $display("FAIL y_zero_acc got=%0d/%0b exp=500/0", r, o); end
        do_op(6'd0, 6'd0, 1'b0, 1'b0, r, o, l, t);
        checks++; if (t || r !== 0 || o !== 1'b0) begin failures++; $display("FAIL all_zero got=%0d/%0b exp=0/0", r, o); end
        model_acc = 0;
    endtask

    task automatic test_random();
        int r, l, er; bit o, t, eo, ae, clr;
        logic [5:0] x, y;
        for (int i = 0; i < 40; i++) begin
            x = 6'($urandom_range(0, 63));
            y = 6'($urandom_range(0, 63));
            ae = 1'($urandom_range(0, 3) != 0);
            clr = 1'($urandom_range(0, 7) == 0);
            model_op(int'(x), int'(y), ae, clr, er, eo);
            do_op(x, y, ae, clr, r, o, l, t);
            checks++;
            if (t || r !== er || o !== eo || l !== 3) begin
                failures++;
                $display("FAIL random_%0d got=%0d/%0b lat %0d exp=%0d/%0b lat 3", i, r, o, l, er, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_acc_clear();
        test_mid_reset();
        test_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac8_operand_sequencer.md
Name: mac8_operand_sequencer

Overview:
Initiator side of the MAC8 three-operand 12-bit adder. It accepts one 6x6 multiply(-accumulate) request over a valid/ready handshake. It splits the request into six partial products and drives the adder with three operands per cycle over three passes. It captures each returned Sum/Carry and delivers a 12-bit product or accumulated result over a valid/ready output handshake.

Parameters:
OP_W, 6, multiplicand/multiplier width
RES_W, 12, result/accumulator/adder width (fixed at 2*OP_W)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  sequencer can accept a request
in_x  in  OP_W  multiplicand, unsigned
in_y  in  OP_W  multiplier, unsigned
in_acc_en  in  1  add held accumulator into this result
acc_clear  in  1  zero the accumulator (honoured in IDLE only)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  RES_W  product or product+acc, mod 2^RES_W
out_ovf  out  1  final pass produced a carry out
add_a  out  RES_W  adder operand A
add_b  out  RES_W  adder operand B
add_c  out  RES_W  adder operand C
add_sum  in  RES_W  adder Sum, combinational from add_a/b/c
add_carry  in  1  adder Carry out

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_ovf=0, acc=0, partial=0, operand regs=0. Mid-operation reset aborts; no output is produced.
- Registered latches x_q, y_q, acc_en_q capture on handshake (in_valid & in_ready).
- Partial products: pp[i] = y_q[i] ? (x_q << i) : 0, i=0..5, zero-extended to RES_W.
- States and transitions:
  - IDLE: in_ready=1; add_* driven 0. Handshake -> P1. No handshake -> stay.
  - P1: add_a/b/c = pp0, pp1, pp2; partial <= add_sum; -> P2.
  - P2: add_a/b/c = partial, pp3, pp4; partial <= add_sum; -> P3.
  - P3: add_a/b/c = partial, pp5, (acc_en_q ? acc : 0); out_result <= add_sum; out_ovf <= add_carry; acc <= add_sum; out_valid <= 1; -> DONE.
  - DONE: out_valid=1, out_result/out_ovf held stable. out_ready=1 -> out_valid<=0, -> IDLE. Otherwise stay.
- add_carry is ignored in P1/P2; a 6x6 product <= 3969 cannot carry. Only the P3 accumulate pass can set out_ovf.
- Latency: handshake at edge N; out_valid high after edge N+3. Back-to-back throughput is one result per 5 cycles with out_ready tied high (IDLE, P1, P2, P3, DONE).
- in_ready=0 in P1..DONE. No request is queued; in_valid outside IDLE is ignored.
- acc_clear in IDLE clears acc at that edge. If a handshake happens on the same edge, the clear wins, and the P3 acc term for that request is 0. acc_clear outside IDLE has no effect.
- acc updates only in P3, regardless of acc_en_q: acc always holds the last result.
- Wrap-around: the result is mod 2^12; out_ovf flags the lost bit; acc keeps the wrapped value.
- add_* are registered outputs (driven from state plus regs), so adder paths begin at flops.

Decomposition:
- Shared package mac8_pkg holds:
  - OP_W/RES_W constants
  - state enum {IDLE, P1, P2, P3, DONE}
- One sub-module, mac8_pp_gen: combinational, x_q/y_q -> six RES_W partial products.
- The adder itself stays external; the sequencer only drives and samples its ports.

Test Plan:
- Reset, then x=5, y=7, acc_en=0, out_ready=1 -> out_valid 3 cycles after handshake, out_result=35, out_ovf=0, in_ready back to 1 one cycle after output handshake.
- x=63, y=63, acc_en=0 -> out_result=3969, out_ovf=0. Then x=63, y=63, acc_en=1 -> out_result=3842 (7938 mod 4096), out_ovf=1, acc=3842.
- Result pending with out_ready=0 for 5 cycles -> out_valid stays 1, out_result stable, in_ready=0, extra in_valid pulses ignored. Raise out_ready -> exactly one transfer.
- acc=100 from a prior op, then acc_clear=1 with handshake x=2, y=3, acc_en=1 -> out_result=6, out_ovf=0.
- Assert rst during P2 of x=9, y=9 -> next cycle IDLE, out_valid=0, acc=0, add_* = 0. A following x=1, y=1 request -> out_result=1.
- y=0 with any x, acc=500, acc_en=1 -> out_result=500. x=0, y=0, acc_en=0 -> out_result=0.
